// File: rtl/ifetch.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding IROM reads and
// buffers responses in a small FIFO toward decode behind a valid/ready handshake.
module ifetch #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        setup,
    input  logic [31:0] first_addr,
    output logic        irom_req,
    output logic [31:0] irom_addr,
    input  logic [31:0] irom_rdata,
    input  logic        irom_rvalid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out
);
    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_SETUP, S_RUN, S_WAIT, S_DISCARD} state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     pc_mem_q  [DEPTH];
    logic [31:0]     pc_mem_d  [DEPTH];
    logic [31:0]     ins_mem_q [DEPTH];
    logic [31:0]     ins_mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            pop, rsp, push, in_wait;
    logic [CW:0]     occ;
    logic [31:0]     pc_plus4;

    assign in_wait  = (state_q == S_WAIT);
    assign rsp      = in_wait & irom_rvalid;
    assign push     = rsp & !br_taken & !setup;
    assign pc_plus4 = pc_q + 32'd4;

    assign instr_valid = (cnt_q != '0) & !br_taken & !setup;
    assign pop         = instr_valid & instr_ready;
    assign instr_out   = instr_valid ? ins_mem_q[rd_ptr_q] : NOP;
    assign pc_out      = instr_valid ? pc_mem_q[rd_ptr_q]  : 32'h0;

    // occ counts the in-flight response so a new request never overruns the buffer
    assign occ      = (CW+1)'(cnt_q) + (CW+1)'(in_wait) - (CW+1)'(pop);
    assign irom_req = ((state_q == S_RUN) | rsp) & (occ < (CW+1)'(DEPTH)) & !br_taken & !setup;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_mem_d  = pc_mem_q;
        ins_mem_d = ins_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        irom_addr = pc_q;

        if (setup) begin
            state_d  = S_SETUP;
            pc_d     = first_addr & ~32'h3;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else if (br_taken) begin
            pc_d     = br_target & ~32'h3;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            state_d  = S_RUN;
            // a request still in flight must have its response dropped
            if ((state_q == S_WAIT || state_q == S_DISCARD) && !irom_rvalid)
                state_d = S_DISCARD;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]  = pc_q;
                ins_mem_d[wr_ptr_q] = irom_rdata;
                wr_ptr_d            = wr_ptr_q + PW'(1);
                pc_d                = pc_plus4;
                irom_addr           = pc_plus4;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);

            unique case (state_q)
                S_SETUP:   state_d = S_RUN;
                S_RUN:     if (irom_req) state_d = S_WAIT;
                S_WAIT:    if (irom_rvalid) state_d = irom_req ? S_WAIT : S_RUN;
                S_DISCARD: if (irom_rvalid) state_d = S_RUN;
                default:   state_d = S_SETUP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_SETUP;
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            pc_mem_q  <= pc_mem_d;
            ins_mem_q <= ins_mem_d;
        end
    end

endmodule
